// File: rtl/hazard_stall_ctrl.sv
// Front-end stall/flush control for load-use, mult/div structural hazards and taken branches.
// Control outputs are combinational (0 cycles); FSM, busy counter and stall counter are registered.
module hazard_stall_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_muldiv,
    input  logic              id_hilo_rd,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        stall_reason,
    output logic              muldiv_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int CW = $clog2(MULDIV_LAT + 1);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu, sh, flush, stall;

    assign flush = ex_branch_taken;
    assign lu    = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign sh    = (state_q == MD_BUSY) && (id_muldiv || id_hilo_rd);
    // Flush wins over both stall sources, so a flushed cycle never stalls.
    assign stall = !flush && (sh || lu);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_reason = 2'd0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            stall_reason = 2'd3;
        end else if (sh || lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_reason = sh ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (id_muldiv && !flush && !stall) begin
                    state_d = MD_BUSY;
                    cnt_d   = CW'(MULDIV_LAT - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign muldiv_busy  = (state_q == MD_BUSY);
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a reference model pushes expected outputs per driven cycle.
module tb_hazard_stall_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_muldiv, id_hilo_rd, ex_mem_read, ex_branch_taken;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, muldiv_busy;
    logic [1:0]  stall_reason;
    logic [15:0] stall_cycles;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, muldiv_busy4;
    logic [1:0]  stall_reason4;
    logic [3:0]  stall_cycles4;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_AW(5), .MULDIV_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .id_hilo_rd(id_hilo_rd), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .stall_reason(stall_reason),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.REG_AW(5), .MULDIV_LAT(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .id_hilo_rd(id_hilo_rd), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write4), .if_id_write(if_id_write4),
        .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4), .stall_reason(stall_reason4),
        .muldiv_busy(muldiv_busy4), .stall_cycles(stall_cycles4)
    );

    typedef struct packed {
        logic        pc;
        logic        ifw;
        logic        ifl;
        logic        bub;
        logic [1:0]  rsn;
        logic        busy;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: remaining busy cycles and the two stall counters.
    int          m_left = 0;
    logic [15:0] m_cnt  = '0;
    logic [3:0]  m_cnt4 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic fl, sh, lu;
        fl = ex_branch_taken;
        sh = (m_left > 0) && (id_muldiv || id_hilo_rd);
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        e.busy = (m_left > 0);
        e.cnt  = m_cnt;
        e.cnt4 = m_cnt4;
        e.ifl  = fl;
        if (fl) begin
            e.pc = 1; e.ifw = 1; e.bub = 1; e.rsn = 2'd3;
        end else if (sh || lu) begin
            e.pc = 0; e.ifw = 0; e.bub = 1; e.rsn = sh ? 2'd2 : 2'd1;
        end else begin
            e.pc = 1; e.ifw = 1; e.bub = 0; e.rsn = 2'd0;
        end
        return e;
    endfunction

    task automatic compare_top();
        exp_t e;
        e = sb.pop_front();
        check("pc_write",     32'(pc_write),      32'(e.pc));
        check("if_id_write",  32'(if_id_write),   32'(e.ifw));
        check("if_id_flush",  32'(if_id_flush),   32'(e.ifl));
        check("id_ex_bubble", 32'(id_ex_bubble),  32'(e.bub));
        check("stall_reason", 32'(stall_reason),  32'(e.rsn));
        check("muldiv_busy",  32'(muldiv_busy),   32'(e.busy));
        check("stall_cycles", 32'(stall_cycles),  32'(e.cnt));
        check("stall_cyc_w4", 32'(stall_cycles4), 32'(e.cnt4));
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic md, input logic hl, input logic mr,
                        input logic [4:0] ert, input logic br);
        exp_t e;
        id_rs = rs; id_rt = rt; id_uses_rt = ur; id_muldiv = md; id_hilo_rd = hl;
        ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br;
        e = model_out();
        sb.push_back(e);
        @(negedge clk);
        compare_top();
        @(posedge clk);
        if (!e.pc) begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            if (m_cnt4 != 4'hF) m_cnt4++;
        end
        if (m_left > 0) m_left--;
        else if (md && e.pc && !br) m_left = LAT;
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_muldiv = 0; id_hilo_rd = 0;
        ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;
    endtask

    task automatic check_reset_state();
        exp_t e;
        e = '{pc: 0, ifw: 0, ifl: 0, bub: 1, rsn: 2'd0, busy: 0, cnt: '0, cnt4: '0};
        sb.push_back(e);
        compare_top();
        m_left = 0; m_cnt = '0; m_cnt4 = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check_reset_state();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs, then clear.
        step(8, 0, 0, 0, 0, 1, 8, 0);
        step(8, 0, 0, 0, 0, 0, 8, 0);
        // Register zero and rt-use qualification.
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 9, 0, 0, 0, 1, 9, 0);
        step(1, 9, 1, 0, 0, 1, 9, 0);
        // Mult/div accepted, mfhi stalled for LAT cycles then proceeds.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
        // Flush during MD_BUSY with mfhi pending; busy still ends on schedule.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
        // Mult/div under flush or load-use stall is not accepted.
        step(0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(3, 0, 0, 1, 0, 1, 3, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // Asynchronous reset in the second MD_BUSY cycle.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk); clear_inputs(); rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // Long stall: the 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) step(5, 0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++)
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 5) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
